// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Backward control path for the IF/ID and ID/EX stage buffers. A shift-register
// scoreboard records the destination register of each in-flight instruction
// from ID/EX issue until register-file write completion. From that, the block
// decides when the front of the pipe must hold, when a bubble enters ID/EX, and
// when IF/ID is flushed after a taken branch or jump.
//
// Ports:
//   clk, rst            pipeline clock; synchronous active-high reset
//   id_valid            ID stage holds a valid instruction
//   id_rs / id_rt       source registers of the ID instruction
//   id_uses_rs/_rt      ID instruction actually reads that source
//   id_rd, id_regwrite  destination register of the ID instruction and its write enable
//   br_taken            branch/jump in slot1 (EX/MEM) resolved taken
//   pc_hold             freeze the PC
//   if_id_hold          IF/ID keeps its contents
//   id_ex_bubble        ID/EX loads a NOP
//   if_id_flush         IF/ID loads a NOP
//   stall_cnt           saturating count of cycles with pc_hold = 1
//
// Handshake: there is none. All outputs are combinational from registered
// state plus the current ID/branch inputs, and the buffers sample them at
// every rising edge of clk.
//
// No FSM: the only state is the scoreboard (sb_v / sb_rd), the flush window
// counter and the stall counter. The scoreboard vectors are plain named
// signals so they can be observed directly.

module pipe_hazard_ctrl #(
    parameter int REG_AW       = 6,
    parameter int PIPE_DEPTH   = 3,   // must be >= 2 (slot1 holds the resolving branch)
    parameter int FLUSH_CYCLES = 2,   // must be >= 1
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              br_taken,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Wide enough to hold FLUSH_CYCLES-1.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    // Scoreboard: slot0 = ID/EX, slot1 = EX/MEM, slot2 = WB (default depth).
    logic [PIPE_DEPTH-1:0]             sb_v;
    logic [PIPE_DEPTH-1:0][REG_AW-1:0] sb_rd;

    logic [FC_W-1:0] flush_cnt;

    logic match_rs;
    logic match_rt;
    logic raw;
    logic flush;
    logic stall;

    // Hazard detection. The WB slot still counts: the register file is only
    // written at the end of that cycle, so a reader in ID cannot see it yet.
    always_comb begin
        match_rs = 1'b0;
        match_rt = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_v[i] && (sb_rd[i] == id_rs)) match_rs = 1'b1;
            if (sb_v[i] && (sb_rd[i] == id_rt)) match_rt = 1'b1;
        end
        raw   = id_valid & ((id_uses_rs & match_rs) | (id_uses_rt & match_rt));
        flush = br_taken | (flush_cnt != '0);
        // The instruction in ID is about to be flushed, so stalling it is pointless.
        stall = raw & ~flush;
    end

    assign pc_hold      = stall;
    assign if_id_hold   = stall;
    assign id_ex_bubble = stall;
    assign if_id_flush  = flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v      <= '0;
            sb_rd     <= '0;
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sb_v[i]  <= sb_v[i-1];
                sb_rd[i] <= sb_rd[i-1];
            end
            // The instruction in ID/EX is younger than the taken branch in
            // slot1: squash it instead of letting it advance.
            if (br_taken) sb_v[1] <= 1'b0;

            // Bubble on flush (which includes br_taken) or stall; otherwise
            // record the issuing instruction's destination.
            sb_v[0]  <= ~flush & ~stall & id_valid & id_regwrite;
            sb_rd[0] <= id_rd;

            // A new taken branch reloads the window even if one is active.
            if (br_taken)
                flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            else if (flush_cnt != '0)
                flush_cnt <= flush_cnt - FC_W'(1);

            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int REG_AW       = 6;
  localparam int PIPE_DEPTH   = 3;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              br_taken;
  logic              pc_hold;
  logic              if_id_hold;
  logic              id_ex_bubble;
  logic              if_id_flush;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .PIPE_DEPTH(PIPE_DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .br_taken(br_taken),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q[k] = {valid, rd} of what entered the pipe k+1 cycles ago (index 0 = newest).
  logic [REG_AW:0] exp_q[$];
  int cyc     = 0;
  int last_br = -100;
  int exp_cnt = 0;
  bit model_ok = 1'b0;

  function automatic bit m_match(input logic [REG_AW-1:0] r);
    foreach (exp_q[k])
      if (exp_q[k][REG_AW] && (exp_q[k][REG_AW-1:0] == r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_flush();
    return br_taken || ((cyc - last_br) < FLUSH_CYCLES);
  endfunction

  function automatic bit m_stall();
    return id_valid && ((id_uses_rs && m_match(id_rs)) || (id_uses_rt && m_match(id_rt)))
           && !m_flush();
  endfunction

  always @(posedge clk) begin
    bit fl;
    bit st;
    if (rst) begin
      exp_q = {};
      for (int k = 0; k < PIPE_DEPTH; k++) exp_q.push_back('0);
      last_br  = -100;
      exp_cnt  = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      fl = m_flush();
      st = m_stall();
      if (st && exp_cnt < CNT_MAX) exp_cnt++;
      if (br_taken) begin
        exp_q[0][REG_AW] = 1'b0;
        last_br = cyc;
      end
      exp_q.push_front({(!fl && !st && id_valid && id_regwrite), id_rd});
      void'(exp_q.pop_back());
    end
    cyc++;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit fl;
    bit st;
    if (model_ok) begin
      fl = m_flush();
      st = m_stall();
      chk("pc_hold",      32'(pc_hold),      32'(st));
      chk("if_id_hold",   32'(if_id_hold),   32'(st));
      chk("id_ex_bubble", 32'(id_ex_bubble), 32'(st));
      chk("if_id_flush",  32'(if_id_flush),  32'(fl));
      chk("stall_cnt",    32'(stall_cnt),    32'(exp_cnt));
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        chk("slot_v", 32'(dut.sb_v[k]), 32'(exp_q[k][REG_AW]));
        if (exp_q[k][REG_AW])
          chk("slot_rd", 32'(dut.sb_rd[k]), 32'(exp_q[k][REG_AW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic v, input int rs, input int rt, input logic urs,
                        input logic urt, input int rd, input logic rw, input logic br);
    id_valid    = v;
    id_rs       = REG_AW'(rs);
    id_rt       = REG_AW'(rt);
    id_uses_rs  = urs;
    id_uses_rt  = urt;
    id_rd       = REG_AW'(rd);
    id_regwrite = rw;
    br_taken    = br;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int holds;
    rst = 1'b1;
    set_id(1, 0, 0, 0, 0, 0, 0, 0);
    next();
    // Second reset cycle: state is cleared, every output must be 0.
    @(negedge clk);
    chk("rst_pc_hold", 32'(pc_hold), 0);
    chk("rst_flush",   32'(if_id_flush), 0);
    chk("rst_bubble",  32'(id_ex_bubble), 0);
    chk("rst_cnt",     32'(stall_cnt), 0);
    next();
    rst = 1'b0;

    // Back-to-back RAW on r5.
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    next();
    set_id(1, 5, 0, 1, 0, 5, 1, 0);
    holds = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!pc_hold) break;
      holds++;
      next();
    end
    chk("b2b_hold_cycles", 32'(holds), 3);
    next();
    chk("b2b_slot0_v",  32'(dut.sb_v[0]), 1);
    chk("b2b_slot0_rd", 32'(dut.sb_rd[0]), 5);
    chk("b2b_stall_cnt", 32'(stall_cnt), 3);

    // Independent stream: rd = rs + 1, no register reused.
    for (int k = 0; k < 10; k++) begin
      set_id(1, 20 + 2 * k, 0, 1, 0, 21 + 2 * k, 1, 0);
      @(negedge clk);
      chk("indep_pc_hold", 32'(pc_hold), 0);
      next();
      chk("indep_slot0_v", 32'(dut.sb_v[0]), 1);
    end

    // Taken branch squashing a writer of r9.
    set_id(1, 0, 0, 0, 0, 9, 1, 0);
    next();
    set_id(1, 0, 0, 0, 0, 12, 1, 1);
    @(negedge clk);
    chk("br_flush_t", 32'(if_id_flush), 1);
    next();
    chk("br_slot1_v", 32'(dut.sb_v[1]), 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("br_flush_t1", 32'(if_id_flush), 1);
    next();
    set_id(1, 9, 0, 1, 0, 13, 1, 0);
    @(negedge clk);
    chk("br_r9_no_stall", 32'(pc_hold), 0);
    chk("br_flush_t2",    32'(if_id_flush), 0);
    next();

    // RAW on r3 in the same cycle as a taken branch.
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    next();
    set_id(1, 3, 0, 1, 0, 4, 1, 1);
    @(negedge clk);
    chk("sb_pc_hold", 32'(pc_hold), 0);
    chk("sb_flush",   32'(if_id_flush), 1);
    next();
    chk("sb_slot0_bubble", 32'(dut.sb_v[0]), 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) next();

    // Reset in the second cycle of a three-cycle stall.
    set_id(1, 0, 0, 0, 0, 7, 1, 0);
    next();
    set_id(1, 7, 0, 1, 0, 8, 1, 0);
    @(negedge clk);
    chk("ms_stall_c1", 32'(pc_hold), 1);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("ms_pc_hold", 32'(pc_hold), 0);
    chk("ms_sb_v",    32'(dut.sb_v), 0);
    chk("ms_cnt",     32'(stall_cnt), 0);
    next();

    // Randomized traffic over a small register set to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      set_id($urandom_range(0, 9) < 8,
             $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 14) == 0);
      next();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
